role_dealer: RTL

- Reader side of the seed ROM interface: picks a seed, drives the ROM address, captures the packed role word after the ROM's one-cycle synchronous latency and validates it.
- Decodes the word into wolf and doctor indices, then reveals roles one player at a time for the game controller and display.
- Sits between the game FSM (start/reveal buttons) and seed_rom.

---
 rtl/lobinho_pkg.sv | 42 ++++
 rtl/role_dealer_if.sv | 14 +
 rtl/role_word_checker.sv | 48 ++++
 rtl/role_dealer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lobinho_pkg.sv
// lobinho_pkg: shared definitions for the werewolf game datapath.
//   - role codes carried two bits per player in a packed role word
//   - default game sizing (players per game, valid seed ROM entries)
//   - dealer state encoding
//   - player_field(): extracts one player's role from a packed word
package lobinho_pkg;

  localparam logic [1:0] ROLE_VILLAGER = 2'b00;
  localparam logic [1:0] ROLE_WOLF     = 2'b01;
  localparam logic [1:0] ROLE_DOCTOR   = 2'b10;
  localparam logic [1:0] ROLE_ILLEGAL  = 2'b11;

  localparam int unsigned NUM_PLAYERS = 5;
  localparam int unsigned NUM_SEEDS   = 20;

  // Widest role word any caller may pass (player ids are 3 bits wide).
  localparam int unsigned MAX_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CAPTURE,
    ST_REVEAL,
    ST_DONE,
    ST_ERROR
  } dealer_state_t;

  // Player 0 sits in the most significant pair of an n-player word.
  // The word is zero-extended into MAX_WORD_W bits by the caller;
  // idx must be below n.
  function automatic logic [1:0] player_field(
    input logic [MAX_WORD_W-1:0] w,
    input int unsigned           n,
    input int unsigned           idx
  );
    logic [MAX_WORD_W-1:0] s;
    s = w >> (2 * (n - 1 - idx));
    return s[1:0];
  endfunction

endpackage

// File: rtl/role_dealer_if.sv
// role_dealer_if: seed ROM read bus.
//   rom_address  address presented to seed_rom (driven by the dealer)
//   rom_data     seed_rom data_out, one-cycle synchronous read latency
// Modports: master = dealer (reader), slave = seed ROM.
interface role_dealer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 10
);
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_address, input rom_data);
  modport slave  (input rom_address, output rom_data);
endinterface

// File: rtl/role_word_checker.sv
// role_word_checker: combinational validation of a packed role word.
//   word      packed role word, player 0 in the MSB pair
//   valid     exactly one wolf, exactly one doctor, no illegal code
//   wolf_id   index of the (last) wolf found
//   doctor_id index of the (last) doctor found
// ids are only meaningful when valid is high.
module role_word_checker
  import lobinho_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = lobinho_pkg::NUM_PLAYERS
) (
  input  logic [2*NUM_PLAYERS-1:0] word,
  output logic                     valid,
  output logic [2:0]               wolf_id,
  output logic [2:0]               doctor_id
);

  logic [3:0] n_wolf;
  logic [3:0] n_doctor;
  logic       bad;
  logic [1:0] f;

  always_comb begin
    n_wolf    = '0;
    n_doctor  = '0;
    bad       = 1'b0;
    wolf_id   = '0;
    doctor_id = '0;
    f         = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      f = player_field(MAX_WORD_W'(word), NUM_PLAYERS, i);
      case (f)
        ROLE_WOLF: begin
          n_wolf  = n_wolf + 4'd1;
          wolf_id = 3'(i);
        end
        ROLE_DOCTOR: begin
          n_doctor  = n_doctor + 4'd1;
          doctor_id = 3'(i);
        end
        ROLE_ILLEGAL: bad = 1'b1;
        default: ;
      endcase
    end
    valid = (n_wolf == 4'd1) && (n_doctor == 4'd1) && !bad;
  end

endmodule

// File: rtl/role_dealer.sv
// role_dealer: reader side of the seed ROM; deals and reveals roles.
//   clock, reset   system clock; synchronous active-high reset
//   start          request a new deal (level, sampled each cycle)
//   reveal_next    advance to the next player while revealing
//   rom            seed ROM bus (rom_address registered, rom_data in)
//   busy           fetch in progress (FETCH/WAIT/CAPTURE)
//   ready          valid roles latched (REVEAL or DONE)
//   error          captured word failed validation
//   roles          latched role word
//   wolf_id        index of the wolf player
//   doctor_id      index of the doctor player
//   reveal_player  player currently being revealed
//   reveal_role    role of reveal_player (00 unless ready)
//   done           every player has been revealed
//   query_player   random-access lookup index
//   query_role     role of query_player (00 unless ready, 11 if out of range)
// A free-running seed counter supplies the ROM address; the player's
// button timing is the source of randomness.
module role_dealer
  import lobinho_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = lobinho_pkg::NUM_PLAYERS,
  parameter int unsigned NUM_SEEDS   = lobinho_pkg::NUM_SEEDS,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     reveal_next,
  role_dealer_if.master            rom,
  output logic                     busy,
  output logic                     ready,
  output logic                     error,
  output logic [2*NUM_PLAYERS-1:0] roles,
  output logic [2:0]               wolf_id,
  output logic [2:0]               doctor_id,
  output logic [2:0]               reveal_player,
  output logic [1:0]               reveal_role,
  output logic                     done,
  input  logic [2:0]               query_player,
  output logic [1:0]               query_role
);

  dealer_state_t     state;
  dealer_state_t     state_n;
  logic [ADDR_W-1:0] seed;
  logic [ADDR_W-1:0] addr_q;
  logic              load_addr;
  logic              capture;
  logic              advance;
  logic              last_player;

  logic              word_valid;
  logic [2:0]        word_wolf;
  logic [2:0]        word_doctor;

  role_word_checker #(
    .NUM_PLAYERS(NUM_PLAYERS)
  ) u_checker (
    .word      (rom.rom_data),
    .valid     (word_valid),
    .wolf_id   (word_wolf),
    .doctor_id (word_doctor)
  );

  assign rom.rom_address = addr_q;
  assign last_player     = (reveal_player == 3'(NUM_PLAYERS - 1));

  always_comb begin
    state_n   = state;
    load_addr = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          load_addr = 1'b1;
          state_n   = ST_FETCH;
        end
      end
      ST_FETCH:   state_n = ST_WAIT;
      ST_WAIT:    state_n = ST_CAPTURE;
      ST_CAPTURE: begin
        capture = 1'b1;
        state_n = word_valid ? ST_REVEAL : ST_ERROR;
      end
      ST_REVEAL: begin
        if (reveal_next) begin
          if (last_player) state_n = ST_DONE;
          else             advance = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      seed          <= '0;
      addr_q        <= '0;
      roles         <= '0;
      wolf_id       <= '0;
      doctor_id     <= '0;
      reveal_player <= '0;
    end else begin
      state <= state_n;
      seed  <= (seed == ADDR_W'(NUM_SEEDS - 1)) ? '0 : seed + ADDR_W'(1);
      if (load_addr) addr_q <= seed;
      if (capture) begin
        roles <= rom.rom_data;
        if (word_valid) begin
          wolf_id       <= word_wolf;
          doctor_id     <= word_doctor;
          reveal_player <= '0;
        end
      end
      if (advance) reveal_player <= reveal_player + 3'd1;
    end
  end

  assign busy  = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_CAPTURE);
  assign ready = (state == ST_REVEAL) || (state == ST_DONE);
  assign error = (state == ST_ERROR);
  assign done  = (state == ST_DONE);

  always_comb begin
    reveal_role = '0;
    if (ready)
      reveal_role = player_field(MAX_WORD_W'(roles), NUM_PLAYERS, 32'(reveal_player));
  end

  always_comb begin
    query_role = '0;
    if (ready) begin
      if (32'(query_player) >= NUM_PLAYERS)
        query_role = ROLE_ILLEGAL;
      else
        query_role = player_field(MAX_WORD_W'(roles), NUM_PLAYERS, 32'(query_player));
    end
  end

endmodule
